botones_antirrebote: RTL and testbench
======================================

BOTONES_ANTIRREBOTE -- requirements
Module: botones_antirrebote

Interface
REQ-001 Parameter N_CANALES, default 4: number of independent button channels, legal range 1..16.
REQ-002 Parameter MUESTRAS, default 8: consecutive differing samples needed to accept a level change, legal range 2..255.
REQ-003 Parameter PRESCALER, default 1: clocks per sample tick, legal range 1..65535; a value of 1 means every clock is a tick.
REQ-004 Parameter T_LARGO, default 0: ticks a press must be held before the first auto-repeat pulse; 0 disables auto-repeat.
REQ-005 Parameter T_REPETIR, default 1: ticks between successive auto-repeat pulses, legal range 1..65535.
REQ-006 clk  input  1  single clock; every register updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 btn  input  N_CANALES  raw asynchronous button levels.
REQ-009 salida  output  N_CANALES  debounced level, registered.
REQ-010 pulso_presion  output  N_CANALES  one-clock pulse on each accepted 0->1 change of salida.
REQ-011 pulso_suelta  output  N_CANALES  one-clock pulse on each accepted 1->0 change of salida.
REQ-012 pulso_repetir  output  N_CANALES  one-clock auto-repeat pulse while a channel is held.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchronizer; only the second flop (s2) feeds the filter.
REQ-014 A shared prescaler counter SHALL count 0..PRESCALER-1 and assert tick in the clock where it equals PRESCALER-1, then wrap to 0.
REQ-015 On each tick, per channel: if s2 == salida, the stability counter SHALL clear to 0; otherwise the counter SHALL increment.
REQ-016 When a tick finds s2 != salida with the counter at MUESTRAS-1, salida SHALL invert and the counter SHALL clear, all on that same edge.
REQ-017 With PRESCALER=1, a btn change held stable SHALL update salida at the (MUESTRAS+2)-th rising edge after the change, counting the first edge that samples the new level as edge 1.
REQ-018 Any s2 sample equal to salida before the count completes SHALL discard the partial count; a glitch shorter than MUESTRAS ticks SHALL never change salida.
REQ-019 pulso_presion / pulso_suelta SHALL assert on the same edge that salida changes and deassert on the next edge.
REQ-020 Each channel SHALL run an auto-repeat FSM with states SUELTO, ESPERA, REPITE.
REQ-021 The FSM SHALL move SUELTO->ESPERA when salida rises, and SHALL load the hold counter with 0.
REQ-022 In ESPERA, the hold counter SHALL count ticks; on reaching T_LARGO-1 it SHALL pulse pulso_repetir, clear the counter, and enter REPITE.
REQ-023 In REPITE, the FSM SHALL pulse pulso_repetir every T_REPETIR ticks, counting from the ESPERA->REPITE transition.
REQ-024 A falling salida SHALL return ESPERA or REPITE to SUELTO on the same edge, with the hold counter cleared and no pulso_repetir.
REQ-025 With T_LARGO=0, the FSM SHALL stay in SUELTO and pulso_repetir SHALL stay 0.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce their pulses in the same clock.
REQ-027 All counters SHALL be sized by $clog2 of their limits and SHALL never wrap past their limits.

Reset
REQ-028 While rst=1 at a rising edge, every register SHALL clear: synchronizers, prescaler, stability and hold counters, salida, all pulse outputs, FSM=SUELTO.
REQ-029 A reset mid-debounce or mid-repeat SHALL abandon that operation; no pulse SHALL be emitted for it.
REQ-030 If btn is held high through reset, after rst falls it SHALL be treated as a new press: salida rises after MUESTRAS+2 edges, with a pulso_presion.

Verification
REQ-031 The bench SHALL cover: defaults, btn[0] 0->1 held -> salida[0]=1 and pulso_presion[0] one clock, at edge 10; other bits unchanged.
REQ-032 The bench SHALL cover: btn[1] high for 7 clocks then low -> salida[1] and all pulses stay 0.
REQ-033 The bench SHALL cover: PRESCALER=4, MUESTRAS=3, btn[2] rises -> salida[2] rises no earlier than 2+3*4-3 and no later than 2+3*4 edges later; pulso_suelta[2] on release follows the same bounds.
REQ-034 The bench SHALL cover: T_LARGO=5, T_REPETIR=2, PRESCALER=1, btn[3] held -> pulso_repetir[3] at 5 ticks after salida rises, then every 2 ticks; release -> pulses stop and pulso_suelta[3] fires.
REQ-035 The bench SHALL cover: rst asserted 4 clocks into a debounce -> all outputs 0 on the next edge; btn still high -> press accepted MUESTRAS+2 edges after rst falls.
REQ-036 The bench SHALL cover: all btn bits rise in the same clock -> all salida bits and all pulso_presion bits assert in the same clock.

Source files
------------

// File: rtl/botones_antirrebote.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, tick-driven stability
// filter, press/release edge pulses and an optional per-channel auto-repeat FSM.
module botones_antirrebote #(
    parameter int N_CANALES = 4,
    parameter int MUESTRAS  = 8,
    parameter int PRESCALER = 1,
    parameter int T_LARGO   = 0,
    parameter int T_REPETIR = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CANALES-1:0] btn,
    output logic [N_CANALES-1:0] salida,
    output logic [N_CANALES-1:0] pulso_presion,
    output logic [N_CANALES-1:0] pulso_suelta,
    output logic [N_CANALES-1:0] pulso_repetir
);

    localparam int PW    = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam int CW    = $clog2(MUESTRAS);
    localparam int T_MAX = (T_LARGO > T_REPETIR) ? T_LARGO : T_REPETIR;
    localparam int HW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [1:0] {SUELTO, ESPERA, REPITE} estado_t;

    logic [N_CANALES-1:0] sync1_q, sync2_q;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick;

    logic [CW-1:0]        estab_q [N_CANALES];
    logic [CW-1:0]        estab_d [N_CANALES];
    logic [HW-1:0]        hold_q  [N_CANALES];
    logic [HW-1:0]        hold_d  [N_CANALES];
    estado_t              estado_q [N_CANALES];
    estado_t              estado_d [N_CANALES];

    logic [N_CANALES-1:0] salida_q, salida_d;
    logic [N_CANALES-1:0] presion_q, presion_d;
    logic [N_CANALES-1:0] suelta_q, suelta_d;
    logic [N_CANALES-1:0] repetir_q, repetir_d;

    always_comb begin
        tick    = (presc_q == PW'(PRESCALER - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        salida_d  = salida_q;
        presion_d = '0;
        suelta_d  = '0;
        repetir_d = '0;
        for (int c = 0; c < N_CANALES; c++) begin
            estab_d[c]  = estab_q[c];
            hold_d[c]   = hold_q[c];
            estado_d[c] = estado_q[c];

            // Stability filter: any sample matching the accepted level discards the partial count.
            if (tick) begin
                if (sync2_q[c] == salida_q[c]) begin
                    estab_d[c] = '0;
                end else if (estab_q[c] == CW'(MUESTRAS - 1)) begin
                    estab_d[c]   = '0;
                    salida_d[c]  = ~salida_q[c];
                    presion_d[c] = ~salida_q[c];
                    suelta_d[c]  = salida_q[c];
                end else begin
                    estab_d[c] = estab_q[c] + CW'(1);
                end
            end

            case (estado_q[c])
                SUELTO: begin
                    if (T_LARGO != 0 && presion_d[c]) begin
                        estado_d[c] = ESPERA;
                        hold_d[c]   = '0;
                    end
                end
                ESPERA: begin
                    if (suelta_d[c]) begin
                        estado_d[c] = SUELTO;
                        hold_d[c]   = '0;
                    end else if (tick) begin
                        if (hold_q[c] == HW'(T_LARGO - 1)) begin
                            repetir_d[c] = 1'b1;
                            hold_d[c]    = '0;
                            estado_d[c]  = REPITE;
                        end else begin
                            hold_d[c] = hold_q[c] + HW'(1);
                        end
                    end
                end
                REPITE: begin
                    // A release always wins over a repeat that would fire on the same edge.
                    if (suelta_d[c]) begin
                        estado_d[c] = SUELTO;
                        hold_d[c]   = '0;
                    end else if (tick) begin
                        if (hold_q[c] == HW'(T_REPETIR - 1)) begin
                            repetir_d[c] = 1'b1;
                            hold_d[c]    = '0;
                        end else begin
                            hold_d[c] = hold_q[c] + HW'(1);
                        end
                    end
                end
                default: begin
                    estado_d[c] = SUELTO;
                    hold_d[c]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            presc_q   <= '0;
            salida_q  <= '0;
            presion_q <= '0;
            suelta_q  <= '0;
            repetir_q <= '0;
            for (int c = 0; c < N_CANALES; c++) begin
                estab_q[c]  <= '0;
                hold_q[c]   <= '0;
                estado_q[c] <= SUELTO;
            end
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            presc_q   <= presc_d;
            salida_q  <= salida_d;
            presion_q <= presion_d;
            suelta_q  <= suelta_d;
            repetir_q <= repetir_d;
            for (int c = 0; c < N_CANALES; c++) begin
                estab_q[c]  <= estab_d[c];
                hold_q[c]   <= hold_d[c];
                estado_q[c] <= estado_d[c];
            end
        end
    end

    assign salida        = salida_q;
    assign pulso_presion = presion_q;
    assign pulso_suelta  = suelta_q;
    assign pulso_repetir = repetir_q;

endmodule

// File: tb/tb_botones_antirrebote.sv
// Bench for botones_antirrebote: three instances with different parameter sets,
// directed scenarios plus random button activity checked against a behavioural model.
module tb_botones_antirrebote;

    logic       clk;
    logic       rst;
    logic [3:0] btn_a, btn_b, btn_c;
    logic [3:0] sal_a, pp_a, ps_a, pr_a;
    logic [3:0] sal_b, pp_b, ps_b, pr_b;
    logic [3:0] sal_c, pp_c, ps_c, pr_c;

    int n_cmp = 0;
    int n_err = 0;

    botones_antirrebote dut_a (
        .clk(clk), .rst(rst), .btn(btn_a), .salida(sal_a),
        .pulso_presion(pp_a), .pulso_suelta(ps_a), .pulso_repetir(pr_a)
    );

    botones_antirrebote #(.MUESTRAS(3), .PRESCALER(4)) dut_b (
        .clk(clk), .rst(rst), .btn(btn_b), .salida(sal_b),
        .pulso_presion(pp_b), .pulso_suelta(ps_b), .pulso_repetir(pr_b)
    );

    botones_antirrebote #(.MUESTRAS(4), .PRESCALER(1), .T_LARGO(5), .T_REPETIR(2)) dut_c (
        .clk(clk), .rst(rst), .btn(btn_c), .salida(sal_c),
        .pulso_presion(pp_c), .pulso_suelta(ps_c), .pulso_repetir(pr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: btn seen two edges late; a change is accepted once it is seen on M
    // consecutive ticks; repeats fire when ticks-held == TL, TL+TR, TL+2TR, ...
    typedef struct packed {
        logic [31:0]      cyc;
        logic [3:0]       s1, s2, lvl, pp, ps, pr, hon;
        logic [3:0][15:0] run;
        logic [3:0][15:0] held;
    } mdl_t;

    mdl_t m_a, m_b, m_c;

    function automatic mdl_t mstep(mdl_t x, logic [3:0] b, logic r, int p, int ms, int tl, int tr);
        mdl_t y = x;
        logic tk;
        int   run_n, held_n;
        if (r) begin
            y = '0;
            return y;
        end
        tk    = ((int'(x.cyc) % p) == p - 1);
        y.cyc = x.cyc + 1;
        y.pp  = '0;
        y.ps  = '0;
        y.pr  = '0;
        for (int c = 0; c < 4; c++) begin
            if (tk) begin
                if (x.s2[c] != x.lvl[c]) begin
                    run_n = int'(x.run[c]) + 1;
                    if (run_n == ms) begin
                        y.lvl[c] = ~x.lvl[c];
                        y.pp[c]  = ~x.lvl[c];
                        y.ps[c]  = x.lvl[c];
                        run_n    = 0;
                    end
                    y.run[c] = 16'(run_n);
                end else begin
                    y.run[c] = '0;
                end
            end
            if (y.ps[c]) begin
                y.hon[c]  = 1'b0;
                y.held[c] = '0;
            end else if (y.pp[c]) begin
                y.hon[c]  = (tl > 0);
                y.held[c] = '0;
            end else if (x.hon[c] && tk) begin
                held_n    = int'(x.held[c]) + 1;
                y.held[c] = 16'(held_n);
                if (held_n == tl || (held_n > tl && ((held_n - tl) % tr) == 0))
                    y.pr[c] = 1'b1;
            end
        end
        y.s2 = x.s1;
        y.s1 = b;
        return y;
    endfunction

    always @(posedge clk) begin
        m_a = mstep(m_a, btn_a, rst, 1, 8, 0, 1);
        m_b = mstep(m_b, btn_b, rst, 4, 3, 0, 1);
        m_c = mstep(m_c, btn_c, rst, 1, 4, 5, 2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        check("a.salida",  {28'd0, sal_a}, {28'd0, m_a.lvl});
        check("a.presion", {28'd0, pp_a},  {28'd0, m_a.pp});
        check("a.suelta",  {28'd0, ps_a},  {28'd0, m_a.ps});
        check("a.repetir", {28'd0, pr_a},  {28'd0, m_a.pr});
        check("b.salida",  {28'd0, sal_b}, {28'd0, m_b.lvl});
        check("b.presion", {28'd0, pp_b},  {28'd0, m_b.pp});
        check("b.suelta",  {28'd0, ps_b},  {28'd0, m_b.ps});
        check("b.repetir", {28'd0, pr_b},  {28'd0, m_b.pr});
        check("c.salida",  {28'd0, sal_c}, {28'd0, m_c.lvl});
        check("c.presion", {28'd0, pp_c},  {28'd0, m_c.pp});
        check("c.suelta",  {28'd0, ps_c},  {28'd0, m_c.ps});
        check("c.repetir", {28'd0, pr_c},  {28'd0, m_c.pr});
    endtask

    task automatic step();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {pr_c, ps_c, pp_c, sal_c, pr_b, ps_b, pp_b, sal_b},   32'd0);
        check(tag, {16'd0, pr_a, ps_a, pp_a, sal_a},                    32'd0);
    endtask

    initial begin
        int         n;
        logic       seen;
        logic       acc;
        logic [15:0] rep_mask;

        rst   = 1'b1;
        btn_a = '0;
        btn_b = '0;
        btn_c = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (3) step();

        // Default instance: press on btn[0] accepted at edge 10.
        btn_a[0] = 1'b1;
        repeat (9) step();
        check("a.edge9_salida", {28'd0, sal_a}, 32'h0);
        step();
        check("a.edge10_salida", {28'd0, sal_a}, 32'h1);
        check("a.edge10_presion", {28'd0, pp_a}, 32'h1);
        step();
        check("a.edge11_presion", {28'd0, pp_a}, 32'h0);
        check("a.edge11_salida", {28'd0, sal_a}, 32'h1);

        // Glitch of 7 clocks on btn[1] must not be accepted.
        btn_a[1] = 1'b1;
        repeat (7) step();
        btn_a[1] = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            acc = acc | sal_a[1] | pp_a[1] | ps_a[1] | pr_a[1];
        end
        check("a.glitch_ignored", {31'd0, acc}, 32'd0);

        // Prescaled instance: acceptance lands in the 11..14 edge window.
        btn_b[2] = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (sal_b[2]) begin n = i; seen = pp_b[2]; break; end
        end
        check("b.rise_in_window", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
        check("b.rise_presion", {31'd0, seen}, 32'd1);
        repeat (5) step();
        btn_b[2] = 1'b0;
        n = 0; seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (!sal_b[2]) begin n = i; seen = ps_b[2]; break; end
        end
        check("b.fall_in_window", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
        check("b.fall_suelta", {31'd0, seen}, 32'd1);

        // Auto-repeat instance: repeats 5, 7, 9, 11 ticks after the press is accepted.
        btn_c[3] = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (sal_c[3]) begin seen = 1'b1; break; end
        end
        check("c.press_seen", {31'd0, seen}, 32'd1);
        rep_mask = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            rep_mask[i] = pr_c[3];
        end
        check("c.repeat_pattern", {16'd0, rep_mask}, 32'h0AA0);
        btn_c[3] = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ps_c[3]) begin seen = 1'b1; break; end
        end
        check("c.release_suelta", {31'd0, seen}, 32'd1);
        check("c.release_no_repeat", {31'd0, pr_c[3]}, 32'd0);
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            acc = acc | pr_c[3];
        end
        check("c.repeats_stopped", {31'd0, acc}, 32'd0);

        // Reset mid-debounce; btn still high afterwards counts as a fresh press.
        btn_a[2] = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_debounce");
        rst = 1'b0;
        repeat (9) step();
        check("a.post_reset_edge9", {28'd0, sal_a}, 32'h0);
        step();
        check("a.post_reset_edge10", {28'd0, sal_a}, 32'h5);
        check("a.post_reset_presion", {28'd0, pp_a}, 32'h5);

        // All channels released, then all pressed in the same clock.
        btn_a = 4'h0;
        repeat (12) step();
        check("a.all_released", {28'd0, sal_a}, 32'h0);
        btn_a = 4'hF;
        repeat (9) step();
        check("a.all_edge9", {28'd0, sal_a}, 32'h0);
        step();
        check("a.all_salida", {28'd0, sal_a}, 32'hF);
        check("a.all_presion", {28'd0, pp_a}, 32'hF);

        // Random button activity with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 5) == 0) btn_a[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) btn_b[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) btn_c[$urandom_range(0, 3)] ^= 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
